// File: rtl/adcseq_pkg.sv
// Shared definitions for the ADC push sequencer: register map, Control and
// Status bit positions, and the push state machine encoding.
package adcseq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GAP    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DROP   = 2'd3;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_TPAT  = 2;

  localparam int STAT_OVF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_GAP
  } seq_state_t;

endpackage

// File: rtl/adcseq_if.sv
// Register bus seen by the sequencer: one shared address for reads and writes,
// combinational read data returned by the slave.
interface adcseq_if;
  logic [31:0] addr;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        write;
  logic        read;

  modport master (output addr, Wdata, write, read, input Rdata);
  modport slave  (input addr, Wdata, write, read, output Rdata);
endinterface

// File: rtl/adcseq_fifo.sv
// Synchronous FIFO with first-word fall-through read data; pointers carry one
// extra wrap bit so that full and empty are distinguishable.
module adcseq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adc_push_sequencer.sv
// Buffers converter samples and pushes them to the correlators, never in a bus
// write cycle. ADCSEQ_TEST_PATTERN_EN adds a counter source selected by Control bit2.
module adc_push_sequencer
  import adcseq_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFE000200
) (
  input  logic        clk,
  input  logic        rst,
  adcseq_if.slave     bus,
  input  logic [15:0] adc_in,
  input  logic        adc_valid,
  output logic [15:0] ADC,
  output logic        PushADC
);

  localparam int AW = $clog2(DEPTH);

  logic        run;
  logic        tp_en;
  logic [7:0]  gap;
  logic        overflow;
  logic [31:0] drop_cnt;

  logic        in_win;
  logic [1:0]  offset;
  logic        wr_ctrl, wr_gap, wr_status, wr_drop, flush;

  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic [15:0] fifo_head;
  logic [15:0] src;
  logic [AW:0] level;

  logic        out_valid;
  logic [15:0] out_data;
  logic        load, full_eff, enq, drop;

  seq_state_t  state_q, state_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;

  logic        unused_bits;
  assign unused_bits = ^{bus.addr[1:0], bus.Wdata[31:17], bus.Wdata[15:8]};

  assign in_win    = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus.addr[3:2];
  assign wr_ctrl   = bus.write && in_win && (offset == REG_CTRL);
  assign wr_gap    = bus.write && in_win && (offset == REG_GAP);
  assign wr_status = bus.write && in_win && (offset == REG_STATUS);
  assign wr_drop   = bus.write && in_win && (offset == REG_DROP);
  assign flush     = wr_ctrl && bus.Wdata[CTRL_FLUSH];

  // A push needs the hold stage, Run, a write-free cycle and an expired gap.
  assign PushADC  = out_valid && run && !bus.write && (state_q != ST_GAP) && !rst;
  assign load     = !fifo_empty && (!out_valid || PushADC) && !flush;
  assign full_eff = fifo_full && !load;
  assign enq      = adc_valid && run && !full_eff && !flush;
  assign drop     = adc_valid && run && full_eff && !flush;
  assign ADC      = out_data;
  assign level    = fifo_count + {{AW{1'b0}}, out_valid};

`ifdef ADCSEQ_TEST_PATTERN_EN
  logic [15:0] tp_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tp_cnt <= '0;
      tp_en  <= 1'b0;
    end else begin
      if (adc_valid && run)
        tp_cnt <= tp_cnt + 1'b1;
      if (wr_ctrl)
        tp_en <= bus.Wdata[CTRL_TPAT];
    end
  end

  assign src = tp_en ? tp_cnt : adc_in;
`else
  assign tp_en = 1'b0;
  assign src   = adc_in;
`endif

  adcseq_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (enq),
    .pop   (load),
    .wdata (src),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // An overflow in the same cycle as a clearing write stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      run      <= 1'b0;
      gap      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_ctrl)
        run <= bus.Wdata[CTRL_RUN];
      if (wr_gap)
        gap <= bus.Wdata[7:0];
      if (drop)
        overflow <= 1'b1;
      else if (wr_status && bus.Wdata[STAT_OVF])
        overflow <= 1'b0;
      if (wr_drop)
        drop_cnt <= '0;
      else if (drop && (drop_cnt != 32'hFFFF_FFFF))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= fifo_head;
    end else if (PushADC) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    if (flush) begin
      state_d   = ST_IDLE;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load)
            state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (PushADC) begin
            if (gap != 8'd0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap;
            end else if (!load) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (gap_cnt_q <= 8'd1) begin
            gap_cnt_d = '0;
            state_d   = (out_valid || load) ? ST_ARMED : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Rdata = '0;
    if (!rst && bus.read && in_win) begin
      case (offset)
        REG_CTRL: begin
          bus.Rdata[CTRL_RUN]  = run;
          bus.Rdata[CTRL_TPAT] = tp_en;
        end
        REG_GAP:    bus.Rdata[7:0] = gap;
        REG_STATUS: begin
          bus.Rdata[AW:0]     = level;
          bus.Rdata[STAT_OVF] = overflow;
        end
        default:    bus.Rdata = drop_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_push_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a queue-based reference model of the sequencer.
`timescale 1ns/1ps
module tb_adc_push_sequencer;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'hFE000200;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_GAP  = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_DROP = BASE + 32'hC;
  localparam logic [31:0] A_OUT  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adc_in;
  logic        adc_valid;
  logic [15:0] ADC;
  logic        PushADC;

  adcseq_if bus ();

  adc_push_sequencer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .adc_in    (adc_in),
    .adc_valid (adc_valid),
    .ADC       (ADC),
    .PushADC   (PushADC)
  );

  always #5 clk = ~clk;

  // Reference model: q holds every stored sample, oldest first; hv says the
  // oldest one has reached the output register.
  logic [15:0] q[$];
  bit          hv;
  bit          m_run, m_tp, m_ovf;
  int          m_gap;
  logic [31:0] m_drop;
  logic [15:0] m_pat;
  int          cyc, gap_until;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd0:    r = {29'b0, m_tp, 1'b0, m_run};
        2'd1:    r = 32'(m_gap);
        2'd2:    r = {15'b0, m_ovf, 16'(q.size())};
        default: r = m_drop;
      endcase
    end
    return r;
  endfunction

  task automatic modelReset();
    q.delete();
    hv = 0; m_run = 0; m_tp = 0; m_ovf = 0; m_gap = 0;
    m_drop = '0; m_pat = '0; cyc = 0; gap_until = 0;
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] d, input bit wr, input bit rd,
                               input logic [31:0] a, input logic [31:0] wd);
    bit          exp_push, in_win, flush, full_eff, accept, drop;
    int          old_size;
    logic [15:0] sample;
    @(negedge clk);
    adc_valid = v; adc_in = d;
    bus.write = wr; bus.read = rd; bus.addr = a; bus.Wdata = wd;
    #1;
    exp_push = hv && m_run && !wr && (cyc >= gap_until);
    checkOutput("push", {31'b0, PushADC}, {31'b0, exp_push});
    if (exp_push)
      checkOutput("adc", {16'b0, ADC}, {16'b0, q[0]});
    if (rd)
      checkOutput("rdata", bus.Rdata, modelRead(a));

    in_win   = (a[31:4] == BASE[31:4]);
    flush    = wr && in_win && (a[3:2] == 2'd0) && wd[1];
    full_eff = ((q.size() - int'(hv)) == DEPTH) && !exp_push;
    sample   = d;
`ifdef ADCSEQ_TEST_PATTERN_EN
    if (m_tp) sample = m_pat;
    if (v && m_run) m_pat = m_pat + 16'd1;
`endif
    accept   = v && m_run && !flush && !full_eff;
    drop     = v && m_run && !flush && full_eff;
    old_size = q.size();
    if (flush) begin
      q.delete();
      hv = 0;
      gap_until = 0;
    end else begin
      if (exp_push) begin
        void'(q.pop_front());
        gap_until = cyc + m_gap + 1;
      end
      hv = (old_size - int'(exp_push)) > 0;
      if (accept) q.push_back(sample);
    end
    if (wr && in_win) begin
      case (a[3:2])
        2'd0: begin
          m_run = wd[0];
`ifdef ADCSEQ_TEST_PATTERN_EN
          m_tp = wd[2];
`endif
        end
        2'd1:    m_gap = int'(wd[7:0]);
        2'd2:    if (wd[16]) m_ovf = 0;
        default: m_drop = '0;
      endcase
    end
    if (drop) begin
      m_ovf = 1;
      if (!(wr && in_win && a[3:2] == 2'd3) && m_drop != 32'hFFFF_FFFF)
        m_drop = m_drop + 32'd1;
    end
    cyc++;
  endtask

  task automatic idleCycles(input int n, input bit rd, input logic [31:0] a);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 16'h0, 0, rd, a, 32'h0);
  endtask

  task automatic doReset(input bit mid_op);
    @(negedge clk);
    rst = 1; adc_valid = 0; bus.write = 0; bus.read = 1; bus.addr = A_STAT; bus.Wdata = '0;
    #1;
    if (mid_op) begin
      checkOutput("rst_push_live", {31'b0, PushADC}, 32'h0);
      checkOutput("rst_rdata_live", bus.Rdata, 32'h0);
    end
    @(negedge clk);
    #1;
    checkOutput("rst_push", {31'b0, PushADC}, 32'h0);
    checkOutput("rst_adc", {16'b0, ADC}, 32'h0);
    checkOutput("rst_rdata", bus.Rdata, 32'h0);
    rst = 0; bus.read = 0;
    modelReset();
  endtask

  initial begin
    rst = 1; adc_valid = 0; adc_in = '0;
    bus.write = 0; bus.read = 0; bus.addr = '0; bus.Wdata = '0;
    modelReset();
    doReset(0);

    idleCycles(1, 1, A_CTRL);
    idleCycles(1, 1, A_GAP);
    idleCycles(1, 1, A_STAT);
    idleCycles(1, 1, A_DROP);

    $display("[TB] back-to-back delivery, Gap=0");
    applyStimulus(0, 0, 1, 0, A_CTRL, 32'h1);
    for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 0, 0, A_OUT, 0);
    idleCycles(6, 0, A_OUT);

    $display("[TB] Gap=3 spacing");
    applyStimulus(0, 0, 1, 0, A_GAP, 32'h3);
    for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 0, 0, A_OUT, 0);
    idleCycles(24, 0, A_OUT);
    idleCycles(1, 1, A_STAT);

    $display("[TB] write suppression of a held sample");
    applyStimulus(0, 0, 1, 0, A_GAP, 32'h0);
    applyStimulus(1, 16'h1234, 0, 0, A_OUT, 0);
    idleCycles(1, 0, A_OUT);
    applyStimulus(0, 0, 1, 0, A_OUT, 32'h0);
    applyStimulus(0, 0, 1, 0, A_OUT, 32'h0);
    idleCycles(3, 0, A_OUT);

    $display("[TB] overflow with a continuous write");
    for (int i = 0; i < 20; i++) applyStimulus(1, 16'(16'h0100 + i), 1, 0, A_OUT, 0);
    applyStimulus(0, 0, 1, 1, A_STAT, 32'h0);
    applyStimulus(0, 0, 0, 1, A_DROP, 32'h0);
    idleCycles(20, 0, A_OUT);
    idleCycles(1, 1, A_STAT);

    $display("[TB] flush coincident with a sample");
    for (int i = 0; i < 5; i++) applyStimulus(1, 16'(16'h0200 + i), 1, 0, A_OUT, 0);
    applyStimulus(1, 16'hBEEF, 1, 0, A_CTRL, 32'h3);
    idleCycles(1, 1, A_STAT);
    idleCycles(1, 1, A_DROP);
    idleCycles(4, 0, A_OUT);

    $display("[TB] Control bit2 test pattern select");
    applyStimulus(0, 0, 1, 0, A_CTRL, 32'h5);
    idleCycles(1, 1, A_CTRL);
    for (int i = 0; i < 3; i++) applyStimulus(1, 16'hA5A5, 0, 0, A_OUT, 0);
    idleCycles(4, 0, A_OUT);
    applyStimulus(0, 0, 1, 0, A_CTRL, 32'h1);

    $display("[TB] randomized traffic");
    begin
      int burst;
      burst = 0;
      for (int i = 0; i < 1500; i++) begin
        bit          v, wr, rd;
        logic [31:0] a, wd;
        int          r;
        v  = ($urandom_range(0, 99) < 55);
        r  = $urandom_range(0, 99);
        wr = 0; wd = '0;
        a  = A_CTRL + 32'(4 * $urandom_range(0, 3));
        if (burst > 0) begin
          burst--; wr = 1; a = A_OUT;
        end else if (r < 3) begin
          burst = $urandom_range(8, 24); wr = 1; a = A_OUT;
        end else if (r < 15) begin
          wr = 1; a = A_OUT;
        end else if (r < 18) begin
          wr = 1; a = A_GAP; wd = 32'($urandom_range(0, 3));
        end else if (r < 21) begin
          wr = 1; a = A_CTRL;
          wd = {29'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 9) != 0)};
        end else if (r < 22) begin
          wr = 1; a = A_STAT; wd = 32'h0001_0000;
        end else if (r < 23) begin
          wr = 1; a = A_DROP; wd = $urandom;
        end
        rd = ($urandom_range(0, 3) == 0);
        applyStimulus(v, 16'($urandom), wr, rd, a, wd);
      end
    end

    $display("[TB] reset while samples are held");
    applyStimulus(0, 0, 1, 0, A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 16'(16'h0300 + i), 1, 0, A_OUT, 0);
    doReset(1);
    idleCycles(1, 1, A_STAT);
    idleCycles(1, 1, A_CTRL);
    idleCycles(3, 0, A_OUT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_push_sequencer.md
Name: adc_push_sequencer

Overview:
- Upstream stage for the correlator bank. Buffers raw converter samples in a small synchronous FIFO and drives the shared ADC/PushADC pair seen by every correlator.
- Correlators drop any push that coincides with a bus write. This block therefore never asserts PushADC in a write cycle, and it retains the held sample until that sample can be delivered.
- Also provides a programmable minimum inter-push gap and overflow accounting through bus-visible registers.

Parameters:
- DEPTH, 16: FIFO entries, power of 2, minimum 4.
- BASE_ADDR, 32'hFE000200: base of the 4-word register window.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- addr  in  32  bus address.
- Wdata  in  32  bus write data.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- Rdata  out  32  combinational read data; 0 when not reading this window or when rst=1.
- adc_in  in  16  raw converter sample, two's complement.
- adc_valid  in  1  sample-present strobe; no backpressure.
- ADC  out  16  sample presented to correlators; registered.
- PushADC  out  1  one-cycle push qualifier to correlators.

Behaviour:
- Registers:
  - +0x0 Control: bit0 Run; bit1 Flush, self-clearing, reads 0; bit2 see Optional Feature.
  - +0x4 Gap[7:0]: idle cycles required between pushes.
  - +0x8 Status, read-only: [AW:0] Level (FIFO count plus held-sample count); bit16 Overflow, sticky, cleared by writing 1 to bit16.
  - +0xC DropCount: 32-bit, saturating at 0xFFFFFFFF, cleared by any write.
- Reset: all registers 0; FIFO empty; hold stage empty; ADC=0; PushADC=0; state IDLE.
- Enqueue:
  - Occurs when adc_valid && Run && !full_eff.
  - full_eff = FIFO full and no FIFO pop in the same cycle. A simultaneous pop and push at full is therefore accepted.
  - adc_valid && Run && full_eff drops the sample, sets Overflow and increments DropCount.
  - adc_valid with Run=0 is ignored and is not counted.
- Hold stage:
  - Consists of out_valid and out_data, with ADC = out_data.
  - Loaded from the FIFO head when out_valid=0, or on the same edge the held sample is pushed. Back-to-back delivery is possible.
- Push: PushADC = out_valid && Run && !write && (state != GAP).
  - PushADC is purely combinational from registers and write.
  - On a push edge the sample is consumed. If Gap != 0, gap_cnt loads Gap and state moves to GAP.
- State machine:
  - IDLE (out_valid=0) -> ARMED when the hold stage loads.
  - ARMED -> IDLE on a push with no reload and Gap=0.
  - ARMED -> GAP on a push with Gap != 0.
  - GAP decrements gap_cnt each cycle; on reaching 0 it moves to ARMED if out_valid, otherwise to IDLE.
  - Gap=0 allows a push every cycle.
- Latency: adc_valid sampled at edge k gives the earliest ADC valid and PushADC high in the cycle after edge k+1, assuming empty FIFO, no write, not in GAP.
- Write suppression: a write to any address in the cycle where PushADC would be asserted blocks the push. The sample stays held and is retried the next cycle. No sample is lost or duplicated.
- Flush:
  - Empties the FIFO and hold stage and forces IDLE with gap_cnt=0 at that edge.
  - Any enqueue in the same cycle is discarded and not counted.
  - Overflow and DropCount are unchanged.
- Run=0: no enqueue and no push; contents are retained. Pushing resumes where it left off when Run returns to 1.
- Reset mid-operation discards all contents on that edge. PushADC is 0 during rst.

Optional Feature:
- Macro: ADCSEQ_TEST_PATTERN_EN.
- Defined: Control bit2 selects an internal 16-bit counter instead of adc_in as the enqueue source. The counter resets to 0 and increments on each adc_valid && Run, whether or not the sample is accepted.
- Undefined: bit2 reads 0, writes to it are ignored, and no counter logic is built.

Decomposition:
- Package adcseq_pkg: register offsets (CTRL, GAP, STATUS, DROP), Control bit indices, Status bit positions, state enum {IDLE, ARMED, GAP}.
- Sub-module adcseq_fifo: parameterised synchronous FIFO with push/pop/full/empty/count. Pointers are AW+1 bits wide to distinguish full from empty.
- Bus decode, hold stage, FSM and counters live in the top module.

Test Plan:
- Run=1, Gap=0, adc_valid on 4 consecutive cycles with 0x0001..0x0004, no writes -> PushADC high on 4 consecutive cycles with ADC=0x0001..0x0004, first push 2 edges after the first valid.
- Gap=3, same 4 samples -> exactly 3 idle cycles between successive PushADC pulses; Level reads 0 afterwards.
- Sample 0x1234 held while write pulses for 2 cycles -> PushADC stays 0 during both write cycles, then asserts once with ADC=0x1234; downstream count of pushes = samples.
- DEPTH=16, Run=1, a write held continuously while 20 samples arrive -> Level=17 (16 FIFO + 1 held), DropCount=3, Overflow=1. Release the write -> 17 pushes delivered in order.
- Flush coincident with adc_valid while 5 samples are queued -> Level=0, no PushADC afterwards, DropCount unchanged.
- With ADCSEQ_TEST_PATTERN_EN, bit2=1, 3 valids -> ADC sequence 0x0000, 0x0001, 0x0002. Without the macro, Control read after writing 0x5 returns 0x1.
